// File: rtl/cpu_pkg.sv
// Shared CPU-wide widths and types, plus the call/return opcode decode used by
// the link stack.
package cpu_pkg;

  localparam int ADDR_W   = 10;
  localparam int LS_DEPTH = 8;

  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [1:0] {
    LS_HOLD = 2'b00,
    LS_POP  = 2'b01,
    LS_PUSH = 2'b10,
    LS_REPL = 2'b11
  } ls_op_e;

  function automatic ls_op_e ls_decode(input logic call, input logic ret);
    ls_op_e op;
    case ({call, ret})
      2'b10:   op = LS_PUSH;
      2'b01:   op = LS_POP;
      2'b11:   op = LS_REPL;
      default: op = LS_HOLD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/link_stack_ptr.sv
// Wrap-around top-of-stack pointer with a saturating occupancy count.
module ls_ptr #(
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         start,
  input  logic                         inc,
  input  logic                         dec,
  input  logic                         replace,
  output logic [$clog2(DEPTH)-1:0]     tp,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [PW-1:0] tp_nxt;
  logic [CW-1:0] count_nxt;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Replace rewrites the top in place, so it leaves pointer and count alone.
  always_comb begin
    tp_nxt    = tp;
    count_nxt = count;
    if (replace) begin
      tp_nxt    = tp;
      count_nxt = count;
    end else if (inc) begin
      tp_nxt    = tp + PW'(1);
      count_nxt = full ? count : count + CW'(1);
    end else if (dec && !empty) begin
      tp_nxt    = tp - PW'(1);
      count_nxt = count - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge start) begin
    if (start) begin
      tp    <= '0;
      count <= '0;
    end else begin
      tp    <= tp_nxt;
      count <= count_nxt;
    end
  end

endmodule

// File: rtl/link_stack.sv
// Hardware return-address stack: pushes PC+1 on a call, presents the top entry
// on rl for the PC to load during a return.
module link_stack
  import cpu_pkg::*;
#(
  parameter int DEPTH = LS_DEPTH,
  parameter int AW    = ADDR_W
) (
  input  logic                         clk,
  input  logic                         start,
  input  logic                         jump2sub,
  input  logic                         retFsub,
  input  logic [AW-1:0]                rp,
  output logic [AW-1:0]                rl,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int PW = $clog2(DEPTH);

  ls_op_e        op;
  logic          inc;
  logic          dec;
  logic          repl;
  logic [PW-1:0] tp;
  logic [AW-1:0] ret_addr;
  logic [AW-1:0] mem [DEPTH];

  assign op       = ls_decode(jump2sub, retFsub);
  assign ret_addr = rp + AW'(1);

  // Call+return on an empty stack has no top to replace, so it acts as a push.
  always_comb begin
    inc  = 1'b0;
    dec  = 1'b0;
    repl = 1'b0;
    case (op)
      LS_PUSH: inc = 1'b1;
      LS_POP:  dec = 1'b1;
      LS_REPL: begin
        if (empty) inc  = 1'b1;
        else       repl = 1'b1;
      end
      default: ;
    endcase
  end

  ls_ptr #(.DEPTH(DEPTH)) u_ptr (
    .clk     (clk),
    .start   (start),
    .inc     (inc),
    .dec     (dec),
    .replace (repl),
    .tp      (tp),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk) begin
    if (inc)
      mem[tp + PW'(1)] <= ret_addr;
    else if (repl)
      mem[tp] <= ret_addr;
  end

  assign rl = empty ? '0 : mem[tp];

  always_ff @(posedge clk or posedge start) begin
    if (start) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (op == LS_PUSH && full)
        overflow <= 1'b1;
      if (op == LS_POP && empty)
        underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_link_stack.sv
// Self-checking bench for link_stack: directed vector table, hand-written
// corner sequences and randomized traffic against a queue-based model.
module tb_link_stack;

  localparam int DEPTH = 8;
  localparam int AW    = 10;

  logic          clk;
  logic          start;
  logic          jump2sub;
  logic          retFsub;
  logic [AW-1:0] rp;
  logic [AW-1:0] rl;
  logic [3:0]    count;
  logic          empty;
  logic          full;
  logic          overflow;
  logic          underflow;

  int tests = 0;
  int fails = 0;

  link_stack #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .start     (start),
    .jump2sub  (jump2sub),
    .retFsub   (retFsub),
    .rp        (rp),
    .rl        (rl),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: newest entry at the back of the queue.
  logic [AW-1:0] mq[$];
  logic          m_ovf;
  logic          m_unf;

  function automatic void m_reset();
    mq.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endfunction

  function automatic void m_step(input logic j, input logic r, input logic [AW-1:0] p);
    logic [AW-1:0] a;
    a = p + 10'd1;
    if (j && !r) begin
      if (mq.size() == DEPTH) begin
        void'(mq.pop_front());
        m_ovf = 1'b1;
      end
      mq.push_back(a);
    end else if (r && !j) begin
      if (mq.size() > 0) void'(mq.pop_back());
      else               m_unf = 1'b1;
    end else if (j && r) begin
      if (mq.size() > 0) mq[mq.size()-1] = a;
      else               mq.push_back(a);
    end
  endfunction

  function automatic logic [AW-1:0] m_rl();
    return (mq.size() > 0) ? mq[mq.size()-1] : '0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [AW-1:0] e_rl, input int e_cnt,
                         input logic e_e, input logic e_f, input logic e_o, input logic e_u);
    chk({tag, ".rl"},        int'(rl),        int'(e_rl));
    chk({tag, ".count"},     int'(count),     e_cnt);
    chk({tag, ".empty"},     int'(empty),     int'(e_e));
    chk({tag, ".full"},      int'(full),      int'(e_f));
    chk({tag, ".overflow"},  int'(overflow),  int'(e_o));
    chk({tag, ".underflow"}, int'(underflow), int'(e_u));
  endtask

  task automatic chk_model(input string tag);
    chk_all(tag, m_rl(), mq.size(), mq.size() == 0, mq.size() == DEPTH, m_ovf, m_unf);
  endtask

  // Called at a negedge: drive inputs, settle, leave sampling to caller.
  task automatic drive(input logic j, input logic r, input logic [AW-1:0] p);
    jump2sub = j;
    retFsub  = r;
    rp       = p;
    #1;
  endtask

  task automatic clock_in(input logic j, input logic r, input logic [AW-1:0] p);
    @(posedge clk);
    m_step(j, r, p);
    @(negedge clk);
  endtask

  task automatic cyc(input string tag, input logic j, input logic r, input logic [AW-1:0] p);
    drive(j, r, p);
    chk_model(tag);
    clock_in(j, r, p);
  endtask

  task automatic do_reset();
    start = 1'b1;
    drive(1'b0, 1'b0, '0);
    @(negedge clk);
    start = 1'b0;
    m_reset();
  endtask

  typedef struct {
    logic          j;
    logic          r;
    logic [AW-1:0] p;
    logic [AW-1:0] e_rl;
    int            e_cnt;
    logic          e_e;
    logic          e_f;
    logic          e_o;
    logic          e_u;
  } vec_t;

  vec_t tbl[15];

  initial begin
    // Expected values are the outputs seen during the row's cycle, before its edge.
    tbl[0]  = '{1'b1, 1'b1, 10'h005, 10'h000, 0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 10'h000, 10'h006, 1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 10'h040, 10'h000, 0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 10'h080, 10'h041, 1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 10'h000, 10'h081, 1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 10'h010, 10'h000, 0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 10'h120, 10'h011, 1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 10'h3FF, 10'h121, 2, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 10'h000, 10'h000, 3, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 10'h000, 10'h121, 2, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 10'h000, 10'h011, 1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 10'h200, 10'h000, 0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 10'h000, 10'h201, 1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 10'h000, 10'h000, 0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 10'h000, 10'h000, 0, 1'b1, 1'b0, 1'b0, 1'b1};

    start    = 1'b1;
    jump2sub = 1'b0;
    retFsub  = 1'b0;
    rp       = '0;
    m_reset();
    #2;
    chk_all("reset", 10'h000, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;

    // Directed table
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].j, tbl[i].r, tbl[i].p);
      chk_all($sformatf("tbl%0d", i), tbl[i].e_rl, tbl[i].e_cnt,
              tbl[i].e_e, tbl[i].e_f, tbl[i].e_o, tbl[i].e_u);
      clock_in(tbl[i].j, tbl[i].r, tbl[i].p);
    end

    // Reset then pop
    do_reset();
    drive(1'b0, 1'b1, '0);
    chk("rstpop.rl", int'(rl), 0);
    clock_in(1'b0, 1'b1, '0);
    drive(1'b0, 1'b0, '0);
    chk("rstpop.underflow", int'(underflow), 1);
    chk("rstpop.count", int'(count), 0);
    chk("rstpop.empty", int'(empty), 1);

    // Overflow: nine pushes into an 8-deep stack
    do_reset();
    for (int i = 0; i < 9; i++) cyc("ovf.push", 1'b1, 1'b0, AW'(i));
    drive(1'b0, 1'b0, '0);
    chk("ovf.full", int'(full), 1);
    chk("ovf.overflow", int'(overflow), 1);
    chk("ovf.count", int'(count), 8);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, '0);
      chk($sformatf("ovf.pop%0d", i), int'(rl), 9 - i);
      clock_in(1'b0, 1'b1, '0);
    end
    drive(1'b0, 1'b0, '0);
    chk("ovf.drained", int'(empty), 1);
    chk("ovf.no_unf_yet", int'(underflow), 0);
    cyc("ovf.pop9", 1'b0, 1'b1, '0);
    drive(1'b0, 1'b0, '0);
    chk("ovf.underflow", int'(underflow), 1);
    chk("ovf.ovf_sticky", int'(overflow), 1);

    // Async reset mid-run with sticky flags still set
    for (int i = 0; i < 3; i++) cyc("arst.push", 1'b1, 1'b0, AW'(10'h100 + i));
    drive(1'b0, 1'b0, '0);
    start = 1'b1;
    #1;
    chk_all("arst", 10'h000, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    start = 1'b0;
    m_reset();
    @(negedge clk);
    cyc("arst.after", 1'b0, 1'b0, '0);

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      int unsigned sel;
      logic [AW-1:0] p;
      sel = $urandom_range(0, 9);
      p   = AW'($urandom);
      if (sel < 4)       cyc("rnd", 1'b1, 1'b0, p);
      else if (sel < 8)  cyc("rnd", 1'b0, 1'b1, p);
      else if (sel == 8) cyc("rnd", 1'b1, 1'b1, p);
      else               cyc("rnd", 1'b0, 1'b0, p);
      if ($urandom_range(0, 299) == 0) do_reset();
    end
    drive(1'b0, 1'b0, '0);
    chk_model("final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
